// File: rtl/iram_pkg.sv
// Shared sizing and types for the 64x16 IRAM FIFO and its backing BRAM.
// The almost-full/almost-empty thresholds only take effect when IRAM_FIFO_ALMOST_EN is defined.
package iram_pkg;

    localparam int IRAM_DEPTH     = 64;
    localparam int IRAM_AW        = 6;
    localparam int IRAM_WIDTH     = 16;
    localparam int IRAM_AF_THRESH = 56;
    localparam int IRAM_AE_THRESH = 4;

    typedef logic [IRAM_AW-1:0]    iram_addr_t;
    typedef logic [IRAM_AW:0]      iram_lvl_t;
    typedef logic [IRAM_WIDTH-1:0] iram_data_t;

    // Wrapping pointer increment; DEPTH is a power of two, so overflow is the wrap.
    function automatic iram_addr_t iram_ptr_inc(input iram_addr_t ptr);
        return ptr + iram_addr_t'(1);
    endfunction

endpackage

// File: rtl/iram_sdp_mem.sv
// Single-clock simple dual-port RAM (1 write, 1 read) with a registered read gated by the
// read enable; only the read register is reset so the array still maps onto block RAM.
module iram_sdp_mem
    import iram_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we,
    input  iram_addr_t waddr,
    input  iram_data_t wdata,
    input  logic       re,
    input  iram_addr_t raddr,
    output iram_data_t rdata
);

    iram_data_t mem_array [IRAM_DEPTH];
    iram_data_t rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[waddr] <= wdata;
        end
    end

    // Output register holds its value whenever re is low, which keeps the FIFO head stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem_array[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/iram_fifo_64x16.sv
// First-word-fall-through FIFO over a 64x16 BRAM; the BRAM read register is the head slot.
// Optional almost_full/almost_empty flags are built when IRAM_FIFO_ALMOST_EN is defined.
module iram_fifo_64x16
    import iram_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  iram_data_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output iram_data_t out_data,
    output iram_lvl_t  level,
`ifdef IRAM_FIFO_ALMOST_EN
    output logic       almost_full,
    output logic       almost_empty,
`endif
    output logic       ovf_err
);

    iram_addr_t wr_ptr_reg,    wr_ptr_next;
    iram_addr_t rd_ptr_reg,    rd_ptr_next;
    iram_lvl_t  ram_cnt_reg,   ram_cnt_next;
    logic       out_valid_reg, out_valid_next;
    logic       ovf_err_reg,   ovf_err_next;

    logic push;
    logic pop;
    logic rd_issue;
    logic ram_we;
    logic ram_re;

    // Capacity is DEPTH in RAM plus one in the read register; ready depends on registers only.
    assign in_ready = (ram_cnt_reg != iram_lvl_t'(IRAM_DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = out_valid_reg & out_ready;
    // No bypass: a word is readable only once ram_cnt_reg has counted it.
    assign rd_issue = (ram_cnt_reg != '0) & (~out_valid_reg | pop);

    // Flush wins over everything: nothing is written or read during the flush cycle.
    assign ram_we = push & ~flush;
    assign ram_re = rd_issue & ~flush;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        ram_cnt_next   = ram_cnt_reg;
        out_valid_next = out_valid_reg;
        ovf_err_next   = ovf_err_reg;

        if (flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            ram_cnt_next   = '0;
            out_valid_next = 1'b0;
            ovf_err_next   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = iram_ptr_inc(wr_ptr_reg);
            end
            if (rd_issue) begin
                rd_ptr_next    = iram_ptr_inc(rd_ptr_reg);
                out_valid_next = 1'b1;
            end else if (pop) begin
                out_valid_next = 1'b0;
            end
            case ({push, rd_issue})
                2'b10:   ram_cnt_next = ram_cnt_reg + iram_lvl_t'(1);
                2'b01:   ram_cnt_next = ram_cnt_reg - iram_lvl_t'(1);
                default: ram_cnt_next = ram_cnt_reg;
            endcase
            if (in_valid & ~in_ready) begin
                ovf_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            ovf_err_reg   <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            ram_cnt_reg   <= ram_cnt_next;
            out_valid_reg <= out_valid_next;
            ovf_err_reg   <= ovf_err_next;
        end
    end

    iram_sdp_mem u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .waddr   (wr_ptr_reg),
        .wdata   (in_data),
        .re      (ram_re),
        .raddr   (rd_ptr_reg),
        .rdata   (out_data)
    );

    assign out_valid = out_valid_reg;
    assign ovf_err   = ovf_err_reg;
    assign level     = ram_cnt_reg + iram_lvl_t'(out_valid_reg);

`ifdef IRAM_FIFO_ALMOST_EN
    assign almost_full  = (level >= iram_lvl_t'(IRAM_AF_THRESH));
    assign almost_empty = (level <= iram_lvl_t'(IRAM_AE_THRESH));
`endif

endmodule

// File: tb/tb_iram_fifo_64x16.sv
// Directed and random stimulus against a queue model of the FIFO, compared every cycle,
// plus literal expectations that pin the model. Define IRAM_FIFO_ALMOST_EN to cover the flags.
module tb_iram_fifo_64x16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [6:0]  level;
    logic        ovf_err;
`ifdef IRAM_FIFO_ALMOST_EN
    logic        almost_full;
    logic        almost_empty;
`endif

    iram_fifo_64x16 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
`ifdef IRAM_FIFO_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: words waiting in RAM, plus the presented head word.
    logic [15:0] mq[$];
    logic        mhv;
    logic [15:0] mhd;
    logic        movf;
    logic [15:0] popped[$];
    int          pop_cyc[$];
    int          cyc = 0;
    int          max_level = 0;
    logic        last_push;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mhv  = 1'b0;
        mhd  = 16'h0000;
        movf = 1'b0;
    endtask

    // One clock: drive inputs, compare all outputs against the model, advance both.
    task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
        int  lvl;
        logic m_rdy, push, pop, issue;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        m_rdy = (mq.size() != 64);
        lvl   = mq.size() + int'(mhv);
        chk("in_ready",  int'(in_ready),  int'(m_rdy));
        chk("out_valid", int'(out_valid), int'(mhv));
        chk("out_data",  int'(out_data),  int'(mhd));
        chk("level",     int'(level),     lvl);
        chk("ovf_err",   int'(ovf_err),   int'(movf));
`ifdef IRAM_FIFO_ALMOST_EN
        chk("almost_full",  int'(almost_full),  int'(lvl >= 56));
        chk("almost_empty", int'(almost_empty), int'(lvl <= 4));
`endif
        if (int'(level) > max_level) max_level = int'(level);
        push = iv && m_rdy;
        pop  = mhv && ordy;
        issue = (mq.size() != 0) && (!mhv || pop);
        last_push = push && !fl;
        if (fl) begin
            mq.delete();
            mhv  = 1'b0;
            movf = 1'b0;
        end else begin
            if (pop) begin
                popped.push_back(mhd);
                pop_cyc.push_back(cyc);
            end
            if (iv && !m_rdy) movf = 1'b1;
            if (issue) begin
                mhd = mq.pop_front();
                mhv = 1'b1;
            end else if (pop) begin
                mhv = 1'b0;
            end
            if (push) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int n, guard, bad, first;
        logic [15:0] v;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
        model_reset();
        #23;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level",     int'(level),     0);
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_data",  int'(out_data),  0);

        // 1: single word latency
        chk("t1_level0", int'(level), 0);
        cycle(1'b1, 16'hA5A5, 1'b1, 1'b0);
        chk("t1_level1", int'(level), 1);
        chk("t1_valid_n1", int'(out_valid), 0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t1_valid_n2", int'(out_valid), 1);
        chk("t1_data", int'(out_data), 16'hA5A5);
        chk("t1_level2", int'(level), 1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t1_level3", int'(level), 0);
        $display("T1 single word: popped=%0d", popped.size());

        // 2: fill to 65 with consumer stalled
        n = 0;
        for (guard = 0; guard < 300 && n < 65; guard++) begin
            cycle(1'b1, 16'(n), 1'b0, 1'b0);
            if (last_push) n++;
        end
        chk("t2_accepted", n, 65);
        chk("t2_in_ready", int'(in_ready), 0);
        chk("t2_level", int'(level), 65);
        chk("t2_head", int'(out_data), 0);

        // 3: overflow attempt then drain
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("t3_ovf", int'(ovf_err), 1);
        chk("t3_level", int'(level), 65);
        popped.delete();
        for (guard = 0; guard < 300 && popped.size() < 65; guard++)
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t3_drained", popped.size(), 65);
        bad = 0;
        for (int i = 0; i < popped.size(); i++) if (popped[i] != 16'(i)) bad++;
        chk("t3_order", bad, 0);
        $display("T3 drain: %0d words, misordered=%0d", popped.size(), bad);

        // 4: 200-word ramp, continuous flow
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        chk("t4_ovf_clr", int'(ovf_err), 0);
        popped.delete(); pop_cyc.delete();
        n = 0;
        for (guard = 0; guard < 600 && popped.size() < 200; guard++) begin
            cycle(n < 200, 16'(16'h1000 + n), 1'b1, 1'b0);
            if (last_push) n++;
        end
        chk("t4_count", popped.size(), 200);
        bad = 0;
        for (int i = 0; i < popped.size(); i++) if (popped[i] != 16'(16'h1000 + i)) bad++;
        chk("t4_order", bad, 0);
        if (pop_cyc.size() == 200) chk("t4_rate", pop_cyc[199] - pop_cyc[0], 199);
        else chk("t4_rate_missing", pop_cyc.size(), 200);
        $display("T4 ramp: %0d words, misordered=%0d", popped.size(), bad);

        // 5: random traffic
        popped.delete();
        n = 0; max_level = 0;
        for (guard = 0; guard < 60000 && popped.size() < 10000; guard++) begin
            cycle(($urandom_range(1) == 1) && n < 10000, 16'($urandom), $urandom_range(1) == 1, 1'b0);
            if (last_push) n++;
        end
        while (popped.size() < 10000 && guard < 62000) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
            guard++;
        end
        chk("t5_count", popped.size(), 10000);
        chk("t5_max_level_ok", int'(max_level <= 65), 1);
        $display("T5 random: %0d words, max level %0d", popped.size(), max_level);

        // 6: flush at level 30 while pushing 0x1234
        for (int i = 0; i < 30; i++) cycle(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
        chk("t6_level30", int'(level), 30);
        cycle(1'b1, 16'h1234, 1'b0, 1'b1);
        chk("t6_level", int'(level), 0);
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_ovf", int'(ovf_err), 0);
        popped.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h3000 + i), 1'b1, 1'b0);
        for (guard = 0; guard < 20 && popped.size() < 3; guard++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t6_count", popped.size(), 3);
        bad = 0;
        for (int i = 0; i < popped.size(); i++) if (popped[i] == 16'h1234) bad++;
        chk("t6_no_1234", bad, 0);
        if (popped.size() > 0) chk("t6_first", int'(popped[0]), 16'h3000);
        $display("T6 flush: post-flush words=%0d", popped.size());

        // 7: asynchronous reset mid-burst
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'(16'h4000 + i), i[0], 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t7_valid", int'(out_valid), 0);
        chk("t7_level", int'(level), 0);
        chk("t7_data", int'(out_data), 0);
        chk("t7_ovf", int'(ovf_err), 0);
        chk("t7_in_ready", int'(in_ready), 1);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        popped.delete();
        cycle(1'b1, 16'h5555, 1'b1, 1'b0);
        for (guard = 0; guard < 10 && popped.size() < 1; guard++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t7_after_cnt", popped.size(), 1);
        if (popped.size() > 0) chk("t7_after_data", int'(popped[0]), 16'h5555);
        $display("T7 reset mid-burst: recovered words=%0d", popped.size());

`ifdef IRAM_FIFO_ALMOST_EN
        // 8: thresholds walked through the per-cycle compare, plus literals
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t8_ae_at4", int'(almost_empty), 1);
        cycle(1'b1, 16'h7, 1'b0, 1'b0);
        chk("t8_ae_at5", int'(almost_empty), 0);
        for (guard = 0; guard < 100 && int'(level) < 55; guard++) cycle(1'b1, 16'h8, 1'b0, 1'b0);
        chk("t8_af_at55", int'(almost_full), 0);
        cycle(1'b1, 16'h9, 1'b0, 1'b0);
        chk("t8_af_at56", int'(almost_full), 1);
        $display("T8 almost flags: level=%0d", level);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
